// File: rtl/half_rate_generation_if.sv
// System clock/reset bundle shared by blocks in the sys clock domain.
// Reset is synchronous and active-high; all consumers sample it on clk rising edge.
interface sys_dom_if;
    logic clk;
    logic sync_rst;

    modport sink (
        input clk,
        input sync_rst
    );
endinterface

// File: rtl/half_rate_generation.sv
// Generates clk_o with a programmable half-period (in sys clocks) plus rise/fall strobes.
// Outputs are registered; no backpressure, rate changes wait for the next half-period boundary.
module half_rate_generation #(
    parameter int RATE_WIDTH = 16
) (
    sys_dom_if.sink                 sys_dom_i,
    input  logic                    gen_en_i,
    input  logic                    idle_level_i,
    input  logic [RATE_WIDTH-1:0]   half_rate_i,
    input  logic                    rate_update_i,
    output logic                    clk_o,
    output logic                    rising_edge_o,
    output logic                    falling_edge_o,
    output logic [RATE_WIDTH-1:0]   active_rate_o,
    output logic                    busy_o,
    output logic                    config_error_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [RATE_WIDTH-1:0] RATE_ONE = RATE_WIDTH'(1);

    state_t                  state_q, state_d;
    logic                    clk_q, clk_d;
    logic                    rise_q, rise_d;
    logic                    fall_q, fall_d;
    logic                    err_q, err_d;
    logic                    idle_lvl_q, idle_lvl_d;
    logic                    first_q, first_d;
    logic [RATE_WIDTH-1:0]   count_q, count_d;
    logic [RATE_WIDTH-1:0]   pend_q, pend_d;
    logic [RATE_WIDTH-1:0]   active_q, active_d;
    logic                    at_toggle;

    always_comb begin
        state_d    = state_q;
        clk_d      = clk_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        err_d      = 1'b0;
        idle_lvl_d = idle_lvl_q;
        first_d    = 1'b0;
        count_d    = count_q;
        pend_d     = pend_q;
        active_d   = active_q;
        // The first RUN cycle holds the count so the opening phase spans active+1 edges.
        at_toggle  = !first_q && (count_q == active_q - RATE_ONE);

        if (rate_update_i) begin
            pend_d = (half_rate_i == '0) ? RATE_ONE : half_rate_i;
            err_d  = (half_rate_i == '0);
        end

        case (state_q)
            IDLE: begin
                clk_d   = idle_level_i;
                count_d = '0;
                if (gen_en_i) begin
                    state_d    = RUN;
                    idle_lvl_d = idle_level_i;
                    active_d   = pend_q;
                    first_d    = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (state_q == RUN && !gen_en_i && clk_q == idle_lvl_q) begin
                    // Already resting at the idle level: stop without a toggle.
                    state_d = IDLE;
                    count_d = '0;
                end else if (at_toggle) begin
                    clk_d    = ~clk_q;
                    rise_d   = ~clk_q;
                    fall_d   = clk_q;
                    count_d  = '0;
                    active_d = pend_q;
                    state_d  = gen_en_i ? RUN : IDLE;
                end else begin
                    if (!first_q) begin
                        count_d = count_q + RATE_ONE;
                    end
                    state_d = gen_en_i ? RUN : DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_dom_i.clk) begin
        if (sys_dom_i.sync_rst) begin
            state_q    <= IDLE;
            clk_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            err_q      <= 1'b0;
            idle_lvl_q <= 1'b0;
            first_q    <= 1'b0;
            count_q    <= '0;
            pend_q     <= RATE_ONE;
            active_q   <= RATE_ONE;
        end else begin
            state_q    <= state_d;
            clk_q      <= clk_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            err_q      <= err_d;
            idle_lvl_q <= idle_lvl_d;
            first_q    <= first_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            active_q   <= active_d;
        end
    end

    assign clk_o          = clk_q;
    assign rising_edge_o  = rise_q;
    assign falling_edge_o = fall_q;
    assign active_rate_o  = active_q;
    assign busy_o         = (state_q != IDLE);
    assign config_error_o = err_q;

endmodule

// File: tb/tb_half_rate_generation.sv
// Bench for half_rate_generation: cycle model feeds a scoreboard, plus directed timing checks.
module tb_half_rate_generation;

    localparam int RW = 16;

    sys_dom_if sys_dom ();

    logic          gen_en_i;
    logic          idle_level_i;
    logic [RW-1:0] half_rate_i;
    logic          rate_update_i;
    logic          clk_o;
    logic          rising_edge_o;
    logic          falling_edge_o;
    logic [RW-1:0] active_rate_o;
    logic          busy_o;
    logic          config_error_o;

    half_rate_generation #(.RATE_WIDTH(RW)) dut (
        .sys_dom_i      (sys_dom),
        .gen_en_i       (gen_en_i),
        .idle_level_i   (idle_level_i),
        .half_rate_i    (half_rate_i),
        .rate_update_i  (rate_update_i),
        .clk_o          (clk_o),
        .rising_edge_o  (rising_edge_o),
        .falling_edge_o (falling_edge_o),
        .active_rate_o  (active_rate_o),
        .busy_o         (busy_o),
        .config_error_o (config_error_o)
    );

    initial sys_dom.clk = 1'b0;
    always #5 sys_dom.clk = ~sys_dom.clk;

    typedef struct packed {
        logic          clk;
        logic          rise;
        logic          fall;
        logic          busy;
        logic          err;
        logic [RW-1:0] act;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: counts down the edges remaining in the current phase.
    int          m_state = 0;
    bit          m_clk = 0, m_rise = 0, m_fall = 0, m_err = 0, m_cap = 0;
    int          m_left = 0;
    logic [RW-1:0] m_pend = 1, m_act = 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [RW-1:0] p_old;
        if (sys_dom.sync_rst) begin
            m_state = 0; m_clk = 0; m_rise = 0; m_fall = 0; m_err = 0; m_cap = 0;
            m_left = 0; m_pend = 1; m_act = 1;
            return;
        end
        p_old  = m_pend;
        m_rise = 0;
        m_fall = 0;
        m_err  = 0;
        if (rate_update_i) begin
            m_pend = (half_rate_i == 0) ? RW'(1) : half_rate_i;
            m_err  = (half_rate_i == 0);
        end
        if (m_state == 0) begin
            m_clk = idle_level_i;
            if (gen_en_i) begin
                m_state = 1;
                m_cap   = idle_level_i;
                m_act   = p_old;
                m_left  = int'(p_old) + 1;
            end
        end else if (m_state == 1 && !gen_en_i && m_clk == m_cap) begin
            m_state = 0;
        end else if (m_left == 1) begin
            m_clk   = !m_clk;
            m_rise  = m_clk;
            m_fall  = !m_clk;
            m_act   = p_old;
            m_left  = int'(p_old);
            m_state = gen_en_i ? 1 : 0;
        end else begin
            m_left  = m_left - 1;
            m_state = gen_en_i ? 1 : 2;
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        e.clk  = m_clk;
        e.rise = m_rise;
        e.fall = m_fall;
        e.busy = (m_state != 0);
        e.err  = m_err;
        e.act  = m_act;
        sb_q.push_back(e);
        @(posedge sys_dom.clk);
        #1;
        e = sb_q.pop_front();
        chk("clk_o",          clk_o,          e.clk);
        chk("rising_edge_o",  rising_edge_o,  e.rise);
        chk("falling_edge_o", falling_edge_o, e.fall);
        chk("busy_o",         busy_o,         e.busy);
        chk("config_error_o", config_error_o, e.err);
        chk("active_rate_o",  active_rate_o,  e.act);
        chk("strobe_excl",    rising_edge_o & falling_edge_o, 1'b0);
    endtask

    // Steps until the requested strobe appears; n = edges taken, -1 if the budget runs out.
    task automatic wait_strobe(input bit want_rise, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (want_rise ? rising_edge_o : falling_edge_o) begin
                n = i;
                return;
            end
        end
    endtask

    task automatic load_rate(input int r);
        rate_update_i = 1'b1;
        half_rate_i   = RW'(r);
        step();
        rate_update_i = 1'b0;
    endtask

    initial begin
        int n;
        sys_dom.sync_rst = 1'b1;
        gen_en_i      = 1'b0;
        idle_level_i  = 1'b0;
        half_rate_i   = '0;
        rate_update_i = 1'b0;
        @(negedge sys_dom.clk);
        step();
        step();
        chk("rst_active", active_rate_o, 1);
        chk("rst_busy", busy_o, 0);
        sys_dom.sync_rst = 1'b0;

        // T1: half-period 3
        load_rate(3);
        gen_en_i = 1'b1;
        step();
        wait_strobe(1'b1, n); chk("t1_first_rise", n, 4);
        wait_strobe(1'b0, n); chk("t1_high_half", n, 3);
        wait_strobe(1'b1, n); chk("t1_low_half", n, 3);

        // T3: rate change mid-half lands on the next toggle
        step();
        load_rate(5);
        wait_strobe(1'b0, n); chk("t3_old_half", n, 1);
        chk("t3_active_switch", active_rate_o, 5);
        wait_strobe(1'b1, n); chk("t3_new_half_lo", n, 5);
        wait_strobe(1'b0, n); chk("t3_new_half_hi", n, 5);

        // T2: divide by two
        load_rate(1);
        wait_strobe(1'b0, n);
        wait_strobe(1'b0, n);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_alt", {rising_edge_o, falling_edge_o}, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // T4: stop while high drains the full phase; stop while low is immediate
        load_rate(3);
        wait_strobe(1'b1, n);
        wait_strobe(1'b1, n);
        gen_en_i = 1'b0;
        wait_strobe(1'b0, n); chk("t4_drain_fall", n, 3);
        chk("t4_drain_busy", busy_o, 0);
        gen_en_i = 1'b1;
        step();
        wait_strobe(1'b1, n);
        wait_strobe(1'b0, n);
        step();
        gen_en_i = 1'b0;
        step();
        chk("t4_low_stop_busy", busy_o, 0);
        chk("t4_low_stop_strobe", {rising_edge_o, falling_edge_o}, 2'b00);

        // T5: zero rate is clamped and flagged
        load_rate(0);
        chk("t5_err_pulse", config_error_o, 1);
        step();
        chk("t5_err_clear", config_error_o, 0);
        gen_en_i = 1'b1;
        step();
        chk("t5_active_one", active_rate_o, 1);
        repeat (4) step();

        // T6: reset mid-run while clk_o is high
        load_rate(3);
        wait_strobe(1'b1, n);
        wait_strobe(1'b1, n);
        step();
        sys_dom.sync_rst = 1'b1;
        step();
        chk("t6_clk", clk_o, 0);
        chk("t6_strobes", {rising_edge_o, falling_edge_o}, 2'b00);
        chk("t6_busy", busy_o, 0);
        chk("t6_active", active_rate_o, 1);
        sys_dom.sync_rst = 1'b0;

        // Random traffic, idle level 1 included
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) gen_en_i = ~gen_en_i;
            if ($urandom_range(0, 19) == 0) idle_level_i = ~idle_level_i;
            rate_update_i = ($urandom_range(0, 9) == 0);
            half_rate_i   = RW'($urandom_range(0, 4));
            sys_dom.sync_rst = ($urandom_range(0, 149) == 0);
            step();
        end
        sys_dom.sync_rst = 1'b0;
        rate_update_i    = 1'b0;

        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
